// File: rtl/gate_chk_pkg.sv
// Shared types, gate bit indices and the golden truth-table function.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gate_chk_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } chk_state_t;

    localparam int NUM_GATES = 6;

    // Bit positions inside obs / expected / fail_mask
    localparam int G_AND  = 0;
    localparam int G_OR   = 1;
    localparam int G_NOTA = 2;
    localparam int G_NAND = 3;
    localparam int G_NOR  = 4;
    localparam int G_XOR  = 5;

    function automatic logic [NUM_GATES-1:0] gate_expected(input logic a, input logic b);
        logic [NUM_GATES-1:0] e;
        e         = '0;
        e[G_AND]  = a & b;
        e[G_OR]   = a | b;
        e[G_NOTA] = ~a;
        e[G_NAND] = ~(a & b);
        e[G_NOR]  = ~(a | b);
        e[G_XOR]  = a ^ b;
        return e;
    endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Golden reference for the basic gate block: a,b -> expected gate outputs.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational.
// Ports: a, b (stimulus) -> expected[5:0] in gate_chk_pkg bit order.
module gate_golden_model
    import gate_chk_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] expected
);

    assign expected = gate_expected(a, b);

endmodule

// File: rtl/gate_result_checker.sv
// Response analyzer: checks observed gate outputs against the golden model, keeps stats, reports a verdict.
// Latency: 1 cycle from transfer to mismatch/stat update; done/pass 1 cycle after the final transfer.
// Backpressure: in_ready is high only in RUN; one vector per cycle, no stalls inside a run.
// Ports: clk, rst (sync, active high), start, in_valid/in_ready handshake with a, b, obs[5:0];
//        busy, done, pass, mismatch pulse, fail_mask[5:0], err_count, vec_count, cov[3:0].
module gate_result_checker
    import gate_chk_pkg::*;
#(
    parameter int NUM_VEC = 4,   // minimum 1
    parameter int CNT_W   = 8    // must satisfy NUM_VEC < 2**CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 a,
    input  logic                 b,
    input  logic [NUM_GATES-1:0] obs,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 mismatch,
    output logic [NUM_GATES-1:0] fail_mask,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     vec_count,
    output logic [3:0]           cov
);

    localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VEC);
    // Full coverage needs all four {a,b} combinations, so short runs can never pass.
    localparam bit               CAN_PASS = (NUM_VEC >= 4);

    chk_state_t           state;
    logic [NUM_GATES-1:0] expected;
    logic [NUM_GATES-1:0] diff;
    logic [3:0]           cov_hit;
    logic [3:0]           cov_next;
    logic [CNT_W-1:0]     vec_next;
    logic [CNT_W-1:0]     err_inc;
    logic                 last_vec;

    gate_golden_model u_golden (
        .a        (a),
        .b        (b),
        .expected (expected)
    );

    assign diff     = obs ^ expected;
    assign cov_next = cov | cov_hit;
    assign vec_next = vec_count + CNT_W'(1);
    assign err_inc  = (err_count == {CNT_W{1'b1}}) ? err_count : err_count + CNT_W'(1);
    assign last_vec = (vec_next == LAST_VEC);

    always_comb begin
        cov_hit           = 4'b0000;
        cov_hit[{a, b}]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            mismatch  <= 1'b0;
            fail_mask <= '0;
            err_count <= '0;
            vec_count <= '0;
            cov       <= '0;
        end else begin
            mismatch <= 1'b0;
            if (start) begin
                // start wins over any vector presented in the same cycle
                state     <= S_RUN;
                in_ready  <= 1'b1;
                busy      <= 1'b1;
                done      <= 1'b0;
                pass      <= 1'b0;
                fail_mask <= '0;
                err_count <= '0;
                vec_count <= '0;
                cov       <= '0;
            end else begin
                case (state)
                    S_RUN: begin
                        if (in_valid) begin
                            fail_mask <= fail_mask | diff;
                            cov       <= cov_next;
                            vec_count <= vec_next;
                            // An X/Z compare result falls into the else branch in
                            // simulation, so unknown outputs are flagged as bad.
                            if (diff == '0) begin
                                if (last_vec) begin
                                    pass <= CAN_PASS && (err_count == '0) && (cov_next == 4'hF);
                                end
                            end else begin
                                mismatch  <= 1'b1;
                                err_count <= err_inc;
                                if (last_vec) begin
                                    pass <= 1'b0;
                                end
                            end
                            if (last_vec) begin
                                state    <= S_DONE;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                            end
                        end
                    end
                    S_IDLE, S_DONE: begin
                        // Inputs ignored; statistics frozen until start.
                    end
                    default: begin
                        state    <= S_IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/gate_result_checker.md
# gate_result_checker

Self-checking response analyzer at the output side of the basic logic-gate block. Accepts observed gate outputs together with the `a`/`b` inputs that produced them, one vector per handshake. Compares each vector against a golden truth-table model, keeps per-gate sticky failure flags and a saturating error count, and tracks which of the four input combinations have been exercised. Reports pass or fail once a programmed number of vectors has been consumed. It replaces eyeballed `$monitor` tables with a hardware/bench-reusable verdict.

## Interface
**Parameters**
- `NUM_VEC`, default 4: vectors consumed per run before the verdict is reported; minimum 1.
- `CNT_W`, default 8: width of `err_count` and `vec_count`; requires `NUM_VEC` < 2^CNT_W.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a new run; clears all statistics.
- `in_valid` in 1: observed vector present.
- `in_ready` out 1: checker accepts a vector; a transfer occurs when `in_valid && in_ready`.
- `a`, `b` in 1 each: stimulus that produced `obs`.
- `obs` in 6: observed outputs; bit order is [0] AND, [1] OR, [2] NOT(a), [3] NAND, [4] NOR, [5] XOR.
- `busy` out 1: run in progress.
- `done` out 1: verdict valid.
- `pass` out 1: run clean; meaningful only while `done`=1.
- `mismatch` out 1: one-cycle pulse flagging a bad vector.
- `fail_mask` out 6: sticky per-gate failure bits, same bit order as `obs`.
- `err_count` out CNT_W: number of vectors with any mismatch; saturating.
- `vec_count` out CNT_W: number of vectors accepted in this run.
- `cov` out 4: sticky coverage; bit index is {a,b}.

## Operation
- **States:** IDLE, RUN, DONE.
  - IDLE: `in_ready`=0. `start` → RUN.
  - RUN: `in_ready`=1, `busy`=1.
  - DONE: `done`=1, `in_ready`=0. `start` → RUN.
- **Entering RUN** from any state via `start` clears `fail_mask`, `err_count`, `vec_count`, `cov`, `pass`, and `done`.
- **`start` during RUN** restarts the run. Any vector presented in that same cycle is not counted.
- **Per accepted vector:**
  - Expected value: {a^b, ~(a|b), ~(a&b), ~a, a|b, a&b}.
  - `diff = obs ^ expected`.
  - `fail_mask |= diff`.
  - `cov[{a,b}] <= 1`.
  - `vec_count` increments.
  - If `diff` is nonzero: `mismatch` pulses and `err_count` increments, saturating at 2^CNT_W-1.
- **RUN → DONE:** on the transfer that makes `vec_count == NUM_VEC`. That vector is fully accounted for before DONE.
- **Verdict:** `pass` = (`err_count`==0) && (`cov`==4'hF), registered on entry to DONE. If `NUM_VEC`<4, `pass` is always 0.
- **`in_valid` outside RUN** is ignored, with no side effects.
- **X/Z on `obs`** counts as a mismatch in simulation only. Synthesis treats it as don't-care.

## Timing
- **Reset values:** state=IDLE; `in_ready`, `busy`, `done`, `pass`, `mismatch` = 0; `fail_mask` = 0; `err_count`, `vec_count` = 0; `cov` = 0.
- **`reset` mid-run** aborts the run with no verdict. All outputs take their reset values on the next edge.
- **`start`:** sampled in cycle N; `busy` and `in_ready` are 1 in cycle N+1.
- **Result latency is 1 cycle.** For a transfer in cycle N, `mismatch`, `fail_mask`, `err_count`, `vec_count`, and `cov` update in N+1.
- **Final transfer in cycle N:** `done` and `pass` are valid in N+1, and `in_ready`=0 in N+1.
- **Throughput:** one vector per cycle. Back-to-back transfers are supported.
- **`mismatch`** is high for exactly one cycle per bad vector, with no gap merging across back-to-back bad vectors.
- **`done`** holds until `start` or `rst`. Statistics are frozen while in DONE.

## Structure
- **Package `gate_chk_pkg`:**
  - State enum.
  - Bit-index constants `G_AND`=0 … `G_XOR`=5.
  - `NUM_GATES`=6.
  - Function `gate_expected(a,b)` returning 6 bits.
- **Sub-module `gate_golden_model`:** combinational a,b → expected[5:0]. It is reused by other benches.
- **`gate_result_checker`:** instantiates `gate_golden_model` and holds the FSM plus all statistics registers.

## Test plan
- **Clean exhaustive run:** `NUM_VEC`=4, correct outputs for ab=00,01,10,11 back-to-back. Required: `done` one cycle after the 4th vector, `pass`=1, `err_count`=0, `cov`=4'hF, `mismatch` never asserted.
- **Stuck XOR bit:** `obs[5]` forced 0 for all 4 vectors. Required: `mismatch` pulses on the ab=01 and 10 vectors only, `err_count`=2, `fail_mask`=6'b100000, `pass`=0.
- **Coverage hole:** 4 correct vectors all with ab=11. Required: `cov`=4'b1000, `err_count`=0, `pass`=0.
- **Saturation:** `CNT_W`=2, `NUM_VEC`=3, every vector has all six bits inverted. Required: `err_count`=3 at DONE, `fail_mask`=6'h3F. A separate variant with `NUM_VEC`=3 and `CNT_W`=2, checking that the error count holds at 3, is also required.
- **Restart and reset:** `start` reasserted after 2 bad vectors → all statistics read 0 next cycle. `rst` during RUN → state IDLE, `in_ready`=0, all outputs 0. `in_valid` in IDLE or DONE → `vec_count` unchanged.
